lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store stage of the 8-bit processor, sitting directly upstream of `data_memory`. It accepts one memory operation at a time from execute over a valid/ready handshake and drives the data memory's `address`, `write_data` and `memwrite` inputs for the required number of cycles. For loads it samples the read data and returns it, with its destination-register tag, to writeback over a second valid/ready handshake.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles for which `mem_addr` must be held stable before `mem_rdata` is valid. Legal range is 1..15; any other value is an elaboration `$error`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  execute presents an operation.
- `req_ready`  out  1  stage can accept an operation.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  8  byte address.
- `req_wdata`  in  8  store data; ignored for loads.
- `req_rd`  in  3  destination register tag; ignored for stores.
- `mem_addr`  out  8  to `data_memory.address`.
- `mem_wdata`  out  8  to `data_memory.write_data`.
- `mem_we`  out  1  to `data_memory.memwrite`.
- `mem_rdata`  in  8  from `data_memory.data_out`.
- `resp_valid`  out  1  load result available.
- `resp_ready`  in  1  writeback accepts the result.
- `resp_data`  out  8  loaded byte.
- `resp_rd`  out  3  tag of the load.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE
  - ACCESS: address phase.
  - WAIT: load latency.
  - RESP: result held for writeback.
- Handshakes:
  - `req_ready` = (state == IDLE). A request is accepted on an edge where `req_valid && req_ready`; `req_we`, `req_addr`, `req_wdata` and `req_rd` are registered on that edge.
  - A response transfers on an edge where `resp_valid && resp_ready`.
- IDLE → ACCESS on accept.
- ACCESS (one cycle):
  - `mem_addr` and `mem_wdata` come from the registered request.
  - Store: `mem_we` = 1 for this cycle only; next state is IDLE; no response is produced.
  - Load: `mem_we` = 0. If `MEM_LAT` = 1, `mem_rdata` is sampled at the end of this cycle and the next state is RESP. Otherwise a 4-bit counter is loaded with `MEM_LAT-1` and the next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, `mem_rdata` is sampled into `resp_data` at the end of that cycle and the next state is RESP.
  - `mem_addr` stays stable throughout.
- RESP:
  - `resp_valid` = 1. `resp_data` and `resp_rd` are held stable until the transfer.
  - On transfer the next state is IDLE.
- `mem_addr` and `mem_wdata` always reflect the last accepted request, including while idle. `mem_we` is 0 in every state except a store's ACCESS cycle.
- Addresses 0x00 and 0xFF have no special handling; there is no address arithmetic and no wrap.
- Requests and responses never overlap: while RESP is stalled, `req_ready` stays 0.
- Reset (sync, `rst_n` = 0 at an edge):
  - State → IDLE; counter → 0.
  - `mem_addr`, `mem_wdata`, `resp_data`, `resp_rd` → 0.
  - `mem_we`, `resp_valid`, `busy` → 0; `req_ready` = 1 from the first cycle after reset.
  - An in-flight operation is dropped: a store in ACCESS at reset does not hold `mem_we` into the next cycle, and a pending load response is discarded.

## Timing
- Accept on edge E.
- Store: `mem_we` is high in cycle E+1 (between edges E and E+1). `req_ready` is high again after edge E+1. Throughput is one store per 2 cycles.
- Load: data is sampled at edge E+MEM_LAT. `resp_valid` is high from edge E+MEM_LAT onward. Load-to-result latency is `MEM_LAT`+1 edges; minimum occupancy is `MEM_LAT`+2 cycles with `resp_ready` tied high.
- `busy` tracks the registered state, so it is high from edge E until return to IDLE.

## Configuration
- `LSU_STORE_FWD_EN` defined:
  - Adds registers `fwd_addr`, `fwd_data` and `fwd_vld`, all 0 on reset. Every accepted store sets `fwd_vld`=1 and updates `fwd_addr`/`fwd_data`.
  - A load accepted with `fwd_vld && req_addr == fwd_addr` goes IDLE → RESP directly, with `resp_data` = `fwd_data`; `resp_valid` is high from edge E+1.
  - Such a load does not update `mem_addr` and never asserts `mem_we`.
- `LSU_STORE_FWD_EN` not defined: no forwarding logic is present, and every load takes the memory path.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges mid-load (in WAIT, `MEM_LAT`=3) → `resp_valid`=0, `mem_we`=0, `req_ready`=1 after release, and no stale response appears.
- Store 0xA5 to 0x10 → `mem_addr`=0x10, `mem_wdata`=0xA5, `mem_we`=1 for exactly one cycle (E+1); `resp_valid` never rises.
- Load 0xFF with `MEM_LAT`=1, memory model returning 0x3C, `req_rd`=5 → `resp_valid` at E+1 with `resp_data`=0x3C and `resp_rd`=5.
- `MEM_LAT`=4 load with `resp_ready` low for 3 cycles → `mem_addr` stable through E+4, and `resp_data`/`resp_rd` held stable while stalled. `req_ready`=0 until the transfer edge, then 1.
- Back-to-back: store 0x77 to 0x20, then load 0x20 with `req_valid` held high → the load is accepted one edge after the store completes and returns 0x77 from memory.
- With `LSU_STORE_FWD_EN`: store 0x99 to 0x40, then load 0x40 while the memory model returns 0x00 → `resp_data`=0x99 at E+1 and `mem_we` stays 0. A load of 0x41 takes the memory path.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: execute request, data_memory and writeback signals.
// slave = the load/store stage, master = its surroundings.
interface lsu_mem_stage_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [2:0] req_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic [2:0] resp_rd;
  logic       busy;

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_rd,
    input  mem_rdata, resp_ready,
    output req_ready, mem_addr, mem_wdata,
    output mem_we, resp_valid, resp_data,
    output resp_rd, busy
  );

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_rd,
    output mem_rdata, resp_ready,
    input  req_ready, mem_addr, mem_wdata,
    input  mem_we, resp_valid, resp_data,
    input  resp_rd, busy
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: one-at-a-time load/store stage in front of data_memory.
// Define LSU_STORE_FWD_EN to add last-store to load forwarding.
module lsu_mem_stage #(
  parameter int MEM_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  lsu_mem_stage_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic       r_we;
  logic       acc;
  logic       hit;
  logic       fwd_ld;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("lsu_mem_stage: MEM_LAT %0d not in 1..15", MEM_LAT);
  end

`ifdef LSU_STORE_FWD_EN
  logic [7:0] fwd_addr;
  logic [7:0] fwd_data;
  logic       fwd_vld;

  assign hit = fwd_vld && (bus.req_addr == fwd_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_addr <= 8'h00;
      fwd_data <= 8'h00;
      fwd_vld  <= 1'b0;
    end else if (acc && bus.req_we) begin
      fwd_addr <= bus.req_addr;
      fwd_data <= bus.req_wdata;
      fwd_vld  <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign acc            = bus.req_valid && bus.req_ready;
  assign fwd_ld         = acc && !bus.req_we && hit;
  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.mem_we     = (state == ACCESS) && r_we;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (acc) state_n = fwd_ld ? RESP : ACCESS;
      ACCESS:
        if (r_we)              state_n = IDLE;
        else if (MEM_LAT == 1) state_n = RESP;
        else                   state_n = WAIT;
      WAIT:
        if (cnt == 4'd1) state_n = RESP;
      RESP:
        if (bus.resp_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      r_we          <= 1'b0;
      bus.mem_addr  <= 8'h00;
      bus.mem_wdata <= 8'h00;
      bus.resp_data <= 8'h00;
      bus.resp_rd   <= 3'd0;
    end else begin
      state <= state_n;
      // A forwarded load never touches the memory port.
      if (acc && !fwd_ld) begin
        bus.mem_addr  <= bus.req_addr;
        bus.mem_wdata <= bus.req_wdata;
        r_we          <= bus.req_we;
      end
      if (acc && !bus.req_we)
        bus.resp_rd <= bus.req_rd;
      if (state == ACCESS && !r_we) begin
        if (MEM_LAT == 1) bus.resp_data <= bus.mem_rdata;
        else              cnt <= 4'(MEM_LAT - 1);
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) bus.resp_data <= bus.mem_rdata;
      end
`ifdef LSU_STORE_FWD_EN
      if (fwd_ld) bus.resp_data <= fwd_data;
`endif
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage at MEM_LAT 1, 3 and 4.
// Memory models return 0xEE until the address has been held long enough.
module tb_lsu_mem_stage;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [7:0] m1 [256];
  logic [7:0] m3 [256];
  logic [7:0] m4 [256];
  logic       z1, z3, z4;
  int         a3, a4;

  lsu_mem_stage_if b1 ();
  lsu_mem_stage_if b3 ();
  lsu_mem_stage_if b4 ();

  lsu_mem_stage #(.MEM_LAT(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  lsu_mem_stage #(.MEM_LAT(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  lsu_mem_stage #(.MEM_LAT(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b1.mem_we) m1[b1.mem_addr] <= b1.mem_wdata;
    if (b3.mem_we) m3[b3.mem_addr] <= b3.mem_wdata;
    if (b4.mem_we) m4[b4.mem_addr] <= b4.mem_wdata;
    if (b3.req_valid && b3.req_ready) a3 <= 0;
    else if (a3 < 99)                 a3 <= a3 + 1;
    if (b4.req_valid && b4.req_ready) a4 <= 0;
    else if (a4 < 99)                 a4 <= a4 + 1;
  end

  assign b1.mem_rdata = z1 ? 8'h00 : m1[b1.mem_addr];
  assign b3.mem_rdata = z3 ? 8'h00 : (a3 >= 2 ? m3[b3.mem_addr] : 8'hEE);
  assign b4.mem_rdata = z4 ? 8'h00 : (a4 >= 3 ? m4[b4.mem_addr] : 8'hEE);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs;
    z1 = 0; z3 = 0; z4 = 0;
    b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0;
    b1.req_wdata = 0; b1.req_rd = 0; b1.resp_ready = 1;
    b3.req_valid = 0; b3.req_we = 0; b3.req_addr = 0;
    b3.req_wdata = 0; b3.req_rd = 0; b3.resp_ready = 1;
    b4.req_valid = 0; b4.req_we = 0; b4.req_addr = 0;
    b4.req_wdata = 0; b4.req_rd = 0; b4.resp_ready = 1;
  endtask

  task automatic store1(input logic [7:0] a, input logic [7:0] d);
    b1.req_valid = 1; b1.req_we = 1; b1.req_addr = a; b1.req_wdata = d;
    tick;
    b1.req_valid = 0;
    tick;
  endtask

  task automatic store4(input logic [7:0] a, input logic [7:0] d);
    b4.req_valid = 1; b4.req_we = 1; b4.req_addr = a; b4.req_wdata = d;
    tick;
    b4.req_valid = 0;
    tick;
  endtask

  task automatic test_reset;
    logic stale;
    rst_n = 0;
    init_inputs;
    tick;
    tick;
    vectors++;
    if ({b3.resp_valid, b3.mem_we, b3.req_ready, b3.busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0010",
        {b3.resp_valid, b3.mem_we, b3.req_ready, b3.busy});
    end
    vectors++;
    if ({b1.mem_addr, b1.mem_wdata, b1.resp_data, b1.resp_rd} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_regs got %h want 0",
        {b1.mem_addr, b1.mem_wdata, b1.resp_data, b1.resp_rd});
    end
    rst_n = 1;
    b3.req_valid = 1; b3.req_we = 0; b3.req_addr = 8'h33; b3.req_rd = 3'd2;
    tick;
    b3.req_valid = 0;
    vectors++;
    if ({b3.busy, b3.req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_preload got %b want 10", {b3.busy, b3.req_ready});
    end
    tick;
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
    vectors++;
    if ({b3.resp_valid, b3.mem_we, b3.req_ready, b3.busy} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_midload got %b want 0010",
        {b3.resp_valid, b3.mem_we, b3.req_ready, b3.busy});
    end
    vectors++;
    if ({b3.mem_addr, b3.resp_data, b3.resp_rd} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_midload_regs got %h want 0",
        {b3.mem_addr, b3.resp_data, b3.resp_rd});
    end
    stale = 0;
    repeat (6) begin
      tick;
      if (b3.resp_valid || b3.busy) stale = 1;
    end
    vectors++;
    if (stale !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stale_resp got %b want 0", stale);
    end
  endtask

  task automatic test_store;
    b1.req_valid = 1; b1.req_we = 1; b1.req_addr = 8'h10; b1.req_wdata = 8'hA5;
    tick;
    b1.req_valid = 0;
    vectors++;
    if ({b1.mem_we, b1.req_ready, b1.busy, b1.resp_valid} !== 4'b1010) begin
      miscompares++;
      $display("FAIL store_access got %b want 1010",
        {b1.mem_we, b1.req_ready, b1.busy, b1.resp_valid});
    end
    vectors++;
    if ({b1.mem_addr, b1.mem_wdata} !== 16'h10A5) begin
      miscompares++;
      $display("FAIL store_bus got %h want 10a5", {b1.mem_addr, b1.mem_wdata});
    end
    tick;
    vectors++;
    if ({b1.mem_we, b1.req_ready, b1.busy, b1.resp_valid} !== 4'b0100) begin
      miscompares++;
      $display("FAIL store_done got %b want 0100",
        {b1.mem_we, b1.req_ready, b1.busy, b1.resp_valid});
    end
    tick;
    vectors++;
    if ({b1.mem_we, b1.resp_valid, b1.mem_addr} !== {2'b00, 8'h10}) begin
      miscompares++;
      $display("FAIL store_idle got %h want 010",
        {b1.mem_we, b1.resp_valid, b1.mem_addr});
    end
  endtask

  task automatic test_load_lat1;
    store1(8'hFF, 8'h3C);
    store1(8'h02, 8'h01);
    b1.req_valid = 1; b1.req_we = 0; b1.req_addr = 8'hFF;
    b1.req_wdata = 8'h00; b1.req_rd = 3'd5;
    tick;
    b1.req_valid = 0;
    vectors++;
    if ({b1.resp_valid, b1.mem_we, b1.busy, b1.mem_addr} !== {3'b001, 8'hFF}) begin
      miscompares++;
      $display("FAIL lat1_access got %h want 1ff",
        {b1.resp_valid, b1.mem_we, b1.busy, b1.mem_addr});
    end
    tick;
    vectors++;
    if ({b1.resp_valid, b1.resp_data, b1.resp_rd} !== {1'b1, 8'h3C, 3'd5}) begin
      miscompares++;
      $display("FAIL lat1_resp got %h want %h",
        {b1.resp_valid, b1.resp_data, b1.resp_rd}, {1'b1, 8'h3C, 3'd5});
    end
    tick;
    vectors++;
    if ({b1.resp_valid, b1.req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL lat1_xfer got %b want 01", {b1.resp_valid, b1.req_ready});
    end
  endtask

  task automatic test_stall_lat4;
    store4(8'h80, 8'h5A);
    store4(8'h81, 8'h00);
    b4.resp_ready = 0;
    b4.req_valid = 1; b4.req_we = 0; b4.req_addr = 8'h80; b4.req_rd = 3'd6;
    tick;
    b4.req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({b4.mem_addr, b4.resp_valid, b4.req_ready} !== {8'h80, 2'b00}) begin
        miscompares++;
        $display("FAIL lat4_hold_%0d got %h want 200", k,
          {b4.mem_addr, b4.resp_valid, b4.req_ready});
      end
      tick;
    end
    vectors++;
    if ({b4.resp_valid, b4.resp_data, b4.resp_rd, b4.mem_addr} !==
        {1'b1, 8'h5A, 3'd6, 8'h80}) begin
      miscompares++;
      $display("FAIL lat4_resp got %h want %h",
        {b4.resp_valid, b4.resp_data, b4.resp_rd, b4.mem_addr},
        {1'b1, 8'h5A, 3'd6, 8'h80});
    end
    z4 = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++;
      if ({b4.resp_valid, b4.req_ready, b4.resp_data, b4.resp_rd} !==
          {2'b10, 8'h5A, 3'd6}) begin
        miscompares++;
        $display("FAIL lat4_stall_%0d got %h want %h", k,
          {b4.resp_valid, b4.req_ready, b4.resp_data, b4.resp_rd},
          {2'b10, 8'h5A, 3'd6});
      end
    end
    b4.resp_ready = 1;
    tick;
    z4 = 0;
    vectors++;
    if ({b4.resp_valid, b4.req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL lat4_xfer got %b want 01", {b4.resp_valid, b4.req_ready});
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int exp_n;
`ifdef LSU_STORE_FWD_EN
    exp_n = 0;
`else
    exp_n = 3;
`endif
    b3.req_valid = 1; b3.req_we = 1; b3.req_addr = 8'h20; b3.req_wdata = 8'h77;
    tick;
    b3.req_we = 0; b3.req_rd = 3'd3;
    vectors++;
    if ({b3.mem_we, b3.req_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_store got %b want 10", {b3.mem_we, b3.req_ready});
    end
    tick;
    vectors++;
    if ({b3.req_ready, b3.busy, b3.mem_we} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_gap got %b want 100", {b3.req_ready, b3.busy, b3.mem_we});
    end
    tick;
    b3.req_valid = 0;
    vectors++;
    if ({b3.busy, b3.req_ready, b3.mem_addr} !== {2'b10, 8'h20}) begin
      miscompares++;
      $display("FAIL b2b_accept got %h want 220",
        {b3.busy, b3.req_ready, b3.mem_addr});
    end
    n = 0;
    while (!b3.resp_valid && n < 10) begin
      tick;
      n++;
    end
    vectors++;
    if (n !== exp_n) begin
      miscompares++;
      $display("FAIL b2b_latency got %0d want %0d", n, exp_n);
    end
    vectors++;
    if ({b3.resp_valid, b3.resp_data, b3.resp_rd} !== {1'b1, 8'h77, 3'd3}) begin
      miscompares++;
      $display("FAIL b2b_data got %h want %h",
        {b3.resp_valid, b3.resp_data, b3.resp_rd}, {1'b1, 8'h77, 3'd3});
    end
    tick;
  endtask

  task automatic test_fwd;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [7:0] exp_a;
`ifdef LSU_STORE_FWD_EN
    exp_v = 1; exp_d = 8'h99; exp_a = 8'h41;
`else
    exp_v = 0; exp_d = 8'h00; exp_a = 8'h40;
`endif
    store1(8'h40, 8'h99);
    z1 = 1;
    b1.req_valid = 1; b1.req_we = 0; b1.req_addr = 8'h41; b1.req_rd = 3'd2;
    tick;
    b1.req_valid = 0;
    vectors++;
    if ({b1.resp_valid, b1.mem_addr} !== {1'b0, 8'h41}) begin
      miscompares++;
      $display("FAIL miss_access got %h want 041", {b1.resp_valid, b1.mem_addr});
    end
    tick;
    vectors++;
    if ({b1.resp_valid, b1.resp_data, b1.resp_rd} !== {1'b1, 8'h00, 3'd2}) begin
      miscompares++;
      $display("FAIL miss_resp got %h want %h",
        {b1.resp_valid, b1.resp_data, b1.resp_rd}, {1'b1, 8'h00, 3'd2});
    end
    tick;
    b1.req_valid = 1; b1.req_we = 0; b1.req_addr = 8'h40; b1.req_rd = 3'd1;
    tick;
    b1.req_valid = 0;
    vectors++;
    if ({b1.resp_valid, b1.mem_we, b1.mem_addr} !== {exp_v, 1'b0, exp_a}) begin
      miscompares++;
      $display("FAIL hit_access got %h want %h",
        {b1.resp_valid, b1.mem_we, b1.mem_addr}, {exp_v, 1'b0, exp_a});
    end
    if (!exp_v) tick;
    vectors++;
    if ({b1.resp_valid, b1.resp_data, b1.resp_rd, b1.mem_we} !==
        {1'b1, exp_d, 3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL hit_resp got %h want %h",
        {b1.resp_valid, b1.resp_data, b1.resp_rd, b1.mem_we},
        {1'b1, exp_d, 3'd1, 1'b0});
    end
    tick;
    z1 = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_store;
    test_load_lat1;
    test_stall_lat4;
    test_back_to_back;
    test_fwd;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
